pattern_player: RTL

//   Plays the stored game pattern back to the player before the input phase.

---
 rtl/pattern_player.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pattern_player.sv
// rtl/pattern_player.sv - replays the stored game pattern on the player LEDs
//
// Purpose:
//   On a start pulse in IDLE, captures the pattern and its length, clamped to
//   PATTERN_W. It then flashes each bit, oldest first, on led1 (bit=1) or
//   led0 (bit=0). Each flash is followed by a dark gap. A one-cycle done pulse
//   marks the end of playback.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin playback (sampled only in IDLE)
//   abort    in   synchronous cancel back to IDLE, no done
//   pattern  in   pattern bits, newest at [0], oldest at [length-1]
//   length   in   number of valid bits to play
//   led0     out  lit while a 0 bit is shown
//   led1     out  lit while a 1 bit is shown
//   bit_idx  out  play-order index of the bit shown (0 = oldest)
//   busy     out  high whenever not IDLE
//   done     out  one-cycle pulse at end of playback

module pattern_player #(
  parameter int PATTERN_W  = 32,
  parameter int COUNT_W    = 16,
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [COUNT_W-1:0]   length,
  output logic                 led0,
  output logic                 led1,
  output logic [COUNT_W-1:0]   bit_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int MAX_PH = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
  logic [COUNT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [COUNT_W-1:0]   len_q, len_d;
  logic [PATTERN_W-1:0] pattern_q, pattern_d;

  logic [COUNT_W-1:0]   len_clamped;
  logic [COUNT_W-1:0]   play_pos;
  logic                 cur_bit;

  assign len_clamped = (length > COUNT_W'(PATTERN_W)) ? COUNT_W'(PATTERN_W) : length;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ph_cnt_q  <= '0;
      bit_idx_q <= '0;
      len_q     <= '0;
      pattern_q <= '0;
    end else begin
      state_q   <= state_d;
      ph_cnt_q  <= ph_cnt_d;
      bit_idx_q <= bit_idx_d;
      len_q     <= len_d;
      pattern_q <= pattern_d;
    end
  end

  // Next-state logic. The phase counter is loaded with (duration-1) on every
  // phase entry and counts down, so a phase ends when it reaches zero.
  always_comb begin
    state_d   = state_q;
    ph_cnt_d  = ph_cnt_q;
    bit_idx_d = bit_idx_q;
    len_d     = len_q;
    pattern_d = pattern_q;

    if (state_q != IDLE && abort) begin
      state_d   = IDLE;
      bit_idx_d = '0;
      ph_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pattern_d = pattern;
            len_d     = len_clamped;
            bit_idx_d = '0;
            if (len_clamped != '0) begin
              state_d  = SHOW;
              ph_cnt_d = PH_W'(ON_CYCLES - 1);
            end else begin
              state_d  = DONE;
            end
          end
        end
        SHOW: begin
          if (ph_cnt_q == '0) begin
            state_d  = GAP;
            ph_cnt_d = PH_W'(GAP_CYCLES - 1);
          end else begin
            ph_cnt_d = ph_cnt_q - PH_W'(1);
          end
        end
        GAP: begin
          if (ph_cnt_q == '0) begin
            if (bit_idx_q == len_q - COUNT_W'(1)) begin
              state_d = DONE;
            end else begin
              state_d   = SHOW;
              bit_idx_d = bit_idx_q + COUNT_W'(1);
              ph_cnt_d  = PH_W'(ON_CYCLES - 1);
            end
          end else begin
            ph_cnt_d = ph_cnt_q - PH_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only. Play order runs oldest first,
  // so play index k maps to pattern bit (len-1-k).
  assign play_pos = len_q - COUNT_W'(1) - bit_idx_q;

  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < PATTERN_W; i++) begin
      if (COUNT_W'(i) == play_pos) cur_bit = pattern_q[i];
    end
    led1    = (state_q == SHOW) &  cur_bit;
    led0    = (state_q == SHOW) & ~cur_bit;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    bit_idx = bit_idx_q;
  end

endmodule
